// File: rtl/lc3bp_mem_pkg.sv
// Shared types and constants for the LC3B D-cache responder slice.
// Contents:
//   dresp_state_t : responder FSM state (IDLE, WAIT, DONE)
//   WE_*          : byte write-enable encodings on dcache_we
//   word_index    : maps a byte address to a word index inside a memory of 'depth' words
package lc3bp_mem_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    DONE = 2'd2
  } dresp_state_t;

  localparam logic [1:0] WE_READ = 2'b00;
  localparam logic [1:0] WE_LO   = 2'b01;
  localparam logic [1:0] WE_HI   = 2'b10;
  localparam logic [1:0] WE_WORD = 2'b11;

  // Bit 0 of the byte address never selects a word; the shift drops it.
  // The modulo lets the memory be smaller than the full 64 KiB space.
  function automatic int unsigned word_index(input logic [15:0] addr, input int unsigned depth);
    return (32'(addr) >> 1) % depth;
  endfunction

endpackage

// File: rtl/lc3bp_dcache_responder_if.sv
// D-cache request/response bundle between the LC3B MEM stage and its data memory.
// Signals:
//   dcache_en   : request valid, held with the other fields until dcache_r is seen
//   dcache_we   : byte write enables (bit0 = [7:0], bit1 = [15:8]); 00 = read
//   dcache_addr : byte address
//   dcache_din  : write data
//   dcache_r    : request complete
//   dcache_dout : read word, valid while dcache_r is high
// Modports: master = core side, slave = memory responder side.
interface lc3bp_dcache_responder_if;

  logic        dcache_en;
  logic [1:0]  dcache_we;
  logic [15:0] dcache_addr;
  logic [15:0] dcache_din;
  logic        dcache_r;
  logic [15:0] dcache_dout;

  modport master (
    output dcache_en, dcache_we, dcache_addr, dcache_din,
    input  dcache_r, dcache_dout
  );

  modport slave (
    input  dcache_en, dcache_we, dcache_addr, dcache_din,
    output dcache_r, dcache_dout
  );

endinterface

// File: rtl/lc3bp_dmem_array.sv
// Word-organised data memory, DEPTH_WORDS x 16 bits.
// Ports:
//   clk, rst_n            : clock and async active-low reset (read register only)
//   wr_en/wr_be/wr_idx/wr_data : byte-enabled synchronous write
//   rd_en/rd_idx/rd_data  : synchronous read; rd_data holds until the next rd_en
//   async_idx/async_data  : combinational read port
// The storage itself is never reset; only the read data register is.
module lc3bp_dmem_array #(
  parameter int DEPTH_WORDS = 32768,
  parameter int IDX_W       = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             wr_en,
  input  logic [1:0]       wr_be,
  input  logic [IDX_W-1:0] wr_idx,
  input  logic [15:0]      wr_data,
  input  logic             rd_en,
  input  logic [IDX_W-1:0] rd_idx,
  output logic [15:0]      rd_data,
  input  logic [IDX_W-1:0] async_idx,
  output logic [15:0]      async_data
);

  logic [15:0] mem [DEPTH_WORDS];
  logic [15:0] rd_data_q;

  // Each byte lane is written independently so partial stores leave the other byte intact.
  always_ff @(posedge clk) begin
    if (wr_en && wr_be[0]) mem[wr_idx][7:0]  <= wr_data[7:0];
    if (wr_en && wr_be[1]) mem[wr_idx][15:8] <= wr_data[15:8];
  end

  // The read register doubles as the responder's registered dout, so it must
  // come out of reset at zero and hold its value between loads.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)     rd_data_q <= '0;
    else if (rd_en) rd_data_q <= mem[rd_idx];
  end

  assign rd_data    = rd_data_q;
  assign async_data = mem[async_idx];

endmodule

// File: rtl/lc3bp_dcache_responder.sv
// Responder end of the LC3B D-cache interface. Accepts one request at a time,
// inserts LATENCY wait cycles, returns dcache_r/dcache_dout and commits the
// byte-enabled write in the completing cycle. LATENCY = 0 is a combinational pass-through.
// Ports:
//   clk, rst_n : clock and async active-low reset
//   dc         : slave side of the D-cache bundle
//   proto_err  : sticky; request fields changed while a request was in flight
//   rd_count   : completed reads (wraps)
//   wr_count   : completed writes (wraps)
module lc3bp_dcache_responder
  import lc3bp_mem_pkg::*;
#(
  parameter int LATENCY     = 2,
  parameter int DEPTH_WORDS = 32768
) (
  input  logic                          clk,
  input  logic                          rst_n,
  lc3bp_dcache_responder_if.slave       dc,
  output logic                          proto_err,
  output logic [15:0]                   rd_count,
  output logic [15:0]                   wr_count
);

  localparam int         IDX_W  = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
  localparam bit         PASS   = (LATENCY == 0);
  localparam logic [3:0] LAT_M1 = (LATENCY == 0) ? 4'd0 : 4'(LATENCY - 1);

  dresp_state_t state_q, state_d;
  logic [3:0]   cnt_q, cnt_d;
  logic [15:0]  addr_q, addr_d;
  logic [1:0]   we_q, we_d;
  logic [15:0]  din_q, din_d;
  logic         proto_err_q, proto_err_d;
  logic [15:0]  rd_count_q, rd_count_d;
  logic [15:0]  wr_count_q, wr_count_d;

  logic             fields_differ;
  logic [IDX_W-1:0] live_idx, latched_idx;
  logic             rd_en, wr_en;
  logic [IDX_W-1:0] rd_idx, wr_idx;
  logic [1:0]       wr_be;
  logic [15:0]      wr_data;
  logic [15:0]      sync_data, async_data;

  assign live_idx    = IDX_W'(word_index(dc.dcache_addr, DEPTH_WORDS));
  assign latched_idx = IDX_W'(word_index(addr_q, DEPTH_WORDS));

  assign fields_differ = (dc.dcache_addr != addr_q) || (dc.dcache_we != we_q) ||
                         (dc.dcache_din != din_q);

  lc3bp_dmem_array #(
    .DEPTH_WORDS (DEPTH_WORDS),
    .IDX_W       (IDX_W)
  ) u_mem (
    .clk        (clk),
    .rst_n      (rst_n),
    .wr_en      (wr_en),
    .wr_be      (wr_be),
    .wr_idx     (wr_idx),
    .wr_data    (wr_data),
    .rd_en      (rd_en),
    .rd_idx     (rd_idx),
    .rd_data    (sync_data),
    .async_idx  (live_idx),
    .async_data (async_data)
  );

  // Next-state, latch, counter and memory-port control. The memory is read
  // one edge before DONE so dout is registered and shows the pre-write word;
  // the write itself only happens on the DONE edge when the core is still
  // asserting en, so an abort or reset never touches memory.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    addr_d      = addr_q;
    we_d        = we_q;
    din_d       = din_q;
    proto_err_d = proto_err_q;
    rd_count_d  = rd_count_q;
    wr_count_d  = wr_count_q;
    rd_en       = 1'b0;
    rd_idx      = latched_idx;
    wr_en       = 1'b0;
    wr_idx      = latched_idx;
    wr_be       = we_q;
    wr_data     = din_q;

    if (PASS) begin
      wr_idx  = live_idx;
      wr_be   = dc.dcache_we;
      wr_data = dc.dcache_din;
      if (dc.dcache_en) begin
        if (dc.dcache_we != WE_READ) begin
          wr_en      = 1'b1;
          wr_count_d = wr_count_q + 16'd1;
        end else begin
          rd_count_d = rd_count_q + 16'd1;
        end
      end
    end else begin
      unique case (state_q)
        IDLE: begin
          if (dc.dcache_en) begin
            addr_d = dc.dcache_addr;
            we_d   = dc.dcache_we;
            din_d  = dc.dcache_din;
            cnt_d  = LAT_M1;
            if (LAT_M1 == 4'd0) begin
              rd_en   = 1'b1;
              rd_idx  = live_idx;
              state_d = DONE;
            end else begin
              state_d = WAIT;
            end
          end
        end
        WAIT: begin
          if (!dc.dcache_en) begin
            state_d = IDLE;
          end else begin
            if (fields_differ) proto_err_d = 1'b1;
            cnt_d = cnt_q - 4'd1;
            if (cnt_q == 4'd1) begin
              rd_en   = 1'b1;
              state_d = DONE;
            end
          end
        end
        DONE: begin
          state_d = IDLE;
          if (dc.dcache_en) begin
            if (fields_differ) proto_err_d = 1'b1;
            if (we_q != WE_READ) begin
              wr_en      = 1'b1;
              wr_count_d = wr_count_q + 16'd1;
            end else begin
              rd_count_d = rd_count_q + 16'd1;
            end
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // State, latched request fields and status registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      addr_q      <= '0;
      we_q        <= WE_READ;
      din_q       <= '0;
      proto_err_q <= 1'b0;
      rd_count_q  <= '0;
      wr_count_q  <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      addr_q      <= addr_d;
      we_q        <= we_d;
      din_q       <= din_d;
      proto_err_q <= proto_err_d;
      rd_count_q  <= rd_count_d;
      wr_count_q  <= wr_count_d;
    end
  end

  // With wait states, r depends only on the registered state; in pass-through
  // mode the request is answered in the same cycle and dout is zero when idle.
  assign dc.dcache_r    = PASS ? dc.dcache_en : (state_q == DONE);
  assign dc.dcache_dout = PASS ? (dc.dcache_en ? async_data : 16'h0000) : sync_data;
  assign proto_err      = proto_err_q;
  assign rd_count       = rd_count_q;
  assign wr_count       = wr_count_q;

endmodule

// File: tb/tb_lc3bp_dcache_responder.sv
// Self-checking bench for lc3bp_dcache_responder. Two instances are exercised:
// dut2 with LATENCY=2 and dut0 with LATENCY=0. Expected read data comes from a
// bench-side memory model and is queued when a request is driven, then popped
// when the DUT raises dcache_r.
module tb_lc3bp_dcache_responder;
  import lc3bp_mem_pkg::*;

  localparam int TB_DEPTH = 256;

  typedef struct {
    logic [15:0] dout;
    bit          chk;
  } exp_t;

  logic clk;
  logic rst_n;

  logic        proto_err2, proto_err0;
  logic [15:0] rd_count2, wr_count2, rd_count0, wr_count0;

  lc3bp_dcache_responder_if dc2 ();
  lc3bp_dcache_responder_if dc0 ();

  lc3bp_dcache_responder #(.LATENCY(2), .DEPTH_WORDS(TB_DEPTH)) dut2 (
    .clk       (clk),
    .rst_n     (rst_n),
    .dc        (dc2),
    .proto_err (proto_err2),
    .rd_count  (rd_count2),
    .wr_count  (wr_count2)
  );

  lc3bp_dcache_responder #(.LATENCY(0), .DEPTH_WORDS(TB_DEPTH)) dut0 (
    .clk       (clk),
    .rst_n     (rst_n),
    .dc        (dc0),
    .proto_err (proto_err0),
    .rd_count  (rd_count0),
    .wr_count  (wr_count0)
  );

  int checks = 0;
  int passed = 0;
  int exp_rd2 = 0;
  int exp_wr2 = 0;
  exp_t sb_q[$];
  logic [15:0] model_mem [int];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  // Queue the expected dout for a LATENCY=2 request and apply its write to the model.
  task automatic push_req(input logic [1:0] we, input logic [15:0] addr, input logic [15:0] din);
    exp_t e;
    int key;
    logic [15:0] old;
    key = int'({1'b0, addr[15:1]}) % TB_DEPTH;
    old = model_mem.exists(key) ? model_mem[key] : 16'hxxxx;
    e.dout = old;
    e.chk  = !$isunknown(old);
    sb_q.push_back(e);
    if (we[0]) old[7:0]  = din[7:0];
    if (we[1]) old[15:8] = din[15:8];
    model_mem[key] = old;
  endtask

  // Drive one request on dut2 and hold it until dcache_r is seen, then let the
  // completing edge pass and drop en. lat counts cycles from the accept cycle.
  task automatic drive2(input logic [1:0] we, input logic [15:0] addr, input logic [15:0] din,
                        output logic [15:0] dout, output int lat, output bit timeout);
    timeout = 1'b1;
    lat     = -1;
    dout    = '0;
    @(posedge clk); #1;
    dc2.dcache_en   = 1'b1;
    dc2.dcache_we   = we;
    dc2.dcache_addr = addr;
    dc2.dcache_din  = din;
    for (int i = 0; i < 20 && timeout; i++) begin
      if (dc2.dcache_r === 1'b1) begin
        dout    = dc2.dcache_dout;
        lat     = i;
        timeout = 1'b0;
      end
      @(posedge clk); #1;
    end
    dc2.dcache_en = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    dc2.dcache_en = 1'b0; dc2.dcache_we = WE_READ; dc2.dcache_addr = '0; dc2.dcache_din = '0;
    dc0.dcache_en = 1'b0; dc0.dcache_we = WE_READ; dc0.dcache_addr = '0; dc0.dcache_din = '0;
    #3;
    checks++; if (dc2.dcache_r !== 1'b0) $display("[TB] FAIL reset_r: got %b expected 0", dc2.dcache_r); else passed++;
    checks++; if (dc2.dcache_dout !== 16'h0000) $display("[TB] FAIL reset_dout: got %h expected 0000", dc2.dcache_dout); else passed++;
    checks++; if (proto_err2 !== 1'b0) $display("[TB] FAIL reset_proto: got %b expected 0", proto_err2); else passed++;
    checks++; if (rd_count2 !== 16'd0 || wr_count2 !== 16'd0)
      $display("[TB] FAIL reset_counts: got rd=%0d wr=%0d expected 0/0", rd_count2, wr_count2); else passed++;
    checks++; if (dc0.dcache_r !== 1'b0 || dc0.dcache_dout !== 16'h0000)
      $display("[TB] FAIL reset_l0_idle: got r=%b dout=%h expected 0/0000", dc0.dcache_r, dc0.dcache_dout); else passed++;
    @(posedge clk); @(posedge clk); #1;
    rst_n = 1'b1;
  endtask

  task automatic test_store_load();
    logic [15:0] dout; int lat; bit to; exp_t e;
    push_req(WE_WORD, 16'h0000, 16'h0005); exp_wr2++;
    drive2(WE_WORD, 16'h0000, 16'h0005, dout, lat, to);
    e = sb_q.pop_front();
    checks++; if (to || lat != 2) $display("[TB] FAIL stw_latency: got %0d (timeout=%0b) expected 2", lat, to); else passed++;
    checks++; if (wr_count2 !== 16'(exp_wr2)) $display("[TB] FAIL stw_wr_count: got %0d expected %0d", wr_count2, exp_wr2); else passed++;
    push_req(WE_READ, 16'h0000, 16'h0000); exp_rd2++;
    drive2(WE_READ, 16'h0000, 16'h0000, dout, lat, to);
    e = sb_q.pop_front();
    checks++; if (to || lat != 2) $display("[TB] FAIL ldw_latency: got %0d (timeout=%0b) expected 2", lat, to); else passed++;
    checks++; if (!e.chk || dout !== e.dout) $display("[TB] FAIL ldw_data: got %h expected %h", dout, e.dout); else passed++;
    checks++; if (rd_count2 !== 16'(exp_rd2)) $display("[TB] FAIL ldw_rd_count: got %0d expected %0d", rd_count2, exp_rd2); else passed++;
  endtask

  task automatic test_byte_writes();
    logic [15:0] dout; int lat; bit to; exp_t e;
    push_req(WE_LO, 16'h0010, 16'h12AB); exp_wr2++;
    drive2(WE_LO, 16'h0010, 16'h12AB, dout, lat, to);
    e = sb_q.pop_front();
    push_req(WE_HI, 16'h0011, 16'hCD34); exp_wr2++;
    drive2(WE_HI, 16'h0011, 16'hCD34, dout, lat, to);
    e = sb_q.pop_front();
    push_req(WE_READ, 16'h0010, 16'h0000); exp_rd2++;
    drive2(WE_READ, 16'h0010, 16'h0000, dout, lat, to);
    e = sb_q.pop_front();
    checks++; if (to || !e.chk || dout !== e.dout || dout !== 16'hCDAB)
      $display("[TB] FAIL byte_merge: got %h expected %h", dout, e.dout); else passed++;
    checks++; if (wr_count2 !== 16'(exp_wr2) || rd_count2 !== 16'(exp_rd2))
      $display("[TB] FAIL byte_counts: got rd=%0d wr=%0d expected %0d/%0d", rd_count2, wr_count2, exp_rd2, exp_wr2); else passed++;
  endtask

  task automatic test_abort();
    logic [15:0] dout; int lat; bit to; exp_t e;
    push_req(WE_WORD, 16'h0020, 16'h1111); exp_wr2++;
    drive2(WE_WORD, 16'h0020, 16'h1111, dout, lat, to);
    e = sb_q.pop_front();
    @(posedge clk); #1;
    dc2.dcache_en = 1'b1; dc2.dcache_we = WE_WORD; dc2.dcache_addr = 16'h0020; dc2.dcache_din = 16'hBEEF;
    @(posedge clk); #1;
    dc2.dcache_en = 1'b0;
    @(posedge clk); #1;
    checks++; if (dc2.dcache_r !== 1'b0) $display("[TB] FAIL abort_r: got %b expected 0", dc2.dcache_r); else passed++;
    checks++; if (wr_count2 !== 16'(exp_wr2) || rd_count2 !== 16'(exp_rd2))
      $display("[TB] FAIL abort_counts: got rd=%0d wr=%0d expected %0d/%0d", rd_count2, wr_count2, exp_rd2, exp_wr2); else passed++;
    push_req(WE_READ, 16'h0020, 16'h0000); exp_rd2++;
    drive2(WE_READ, 16'h0020, 16'h0000, dout, lat, to);
    e = sb_q.pop_front();
    checks++; if (to || lat != 2) $display("[TB] FAIL abort_back_to_idle: got latency %0d expected 2", lat); else passed++;
    checks++; if (!e.chk || dout !== e.dout) $display("[TB] FAIL abort_no_write: got %h expected %h", dout, e.dout); else passed++;
  endtask

  task automatic test_back_to_back();
    logic [15:0] addrs [3];
    int rcyc [3];
    int k, cyc;
    exp_t e;
    addrs[0] = 16'h0000; addrs[1] = 16'h0010; addrs[2] = 16'h0020;
    for (int j = 0; j < 3; j++) begin
      push_req(WE_READ, addrs[j], 16'h0000);
      exp_rd2++;
      rcyc[j] = -1;
    end
    k = 0; cyc = 0;
    @(posedge clk); #1;
    dc2.dcache_en = 1'b1; dc2.dcache_we = WE_READ; dc2.dcache_din = '0; dc2.dcache_addr = addrs[0];
    while (k < 3 && cyc < 40) begin
      if (dc2.dcache_r === 1'b1) begin
        e = sb_q.pop_front();
        checks++; if (!e.chk || dc2.dcache_dout !== e.dout)
          $display("[TB] FAIL b2b_data%0d: got %h expected %h", k, dc2.dcache_dout, e.dout); else passed++;
        rcyc[k] = cyc;
        k++;
      end
      @(posedge clk); #1;
      cyc++;
      if (k < 3) dc2.dcache_addr = addrs[k];
      else       dc2.dcache_en   = 1'b0;
    end
    dc2.dcache_en = 1'b0;
    checks++; if (k != 3) $display("[TB] FAIL b2b_complete: got %0d responses expected 3", k); else passed++;
    checks++; if (rcyc[0] != 2 || rcyc[1] - rcyc[0] != 3 || rcyc[2] - rcyc[1] != 3)
      $display("[TB] FAIL b2b_spacing: got r at %0d,%0d,%0d expected 2,5,8", rcyc[0], rcyc[1], rcyc[2]); else passed++;
    checks++; if (rd_count2 !== 16'(exp_rd2)) $display("[TB] FAIL b2b_rd_count: got %0d expected %0d", rd_count2, exp_rd2); else passed++;
  endtask

  task automatic test_proto_err();
    logic [15:0] dout; int lat; bit to; exp_t e;
    bit got_r;
    push_req(WE_READ, 16'h0010, 16'h0000); exp_rd2++;
    got_r = 1'b0;
    dout = '0;
    @(posedge clk); #1;
    dc2.dcache_en = 1'b1; dc2.dcache_we = WE_READ; dc2.dcache_addr = 16'h0010; dc2.dcache_din = '0;
    @(posedge clk); #1;
    dc2.dcache_addr = 16'h0000;
    for (int i = 0; i < 20 && !got_r; i++) begin
      if (dc2.dcache_r === 1'b1) begin
        got_r = 1'b1;
        dout  = dc2.dcache_dout;
      end
      @(posedge clk); #1;
    end
    dc2.dcache_en = 1'b0;
    e = sb_q.pop_front();
    checks++; if (!got_r || !e.chk || dout !== e.dout)
      $display("[TB] FAIL proto_latched_addr: got %h expected %h", dout, e.dout); else passed++;
    checks++; if (proto_err2 !== 1'b1) $display("[TB] FAIL proto_set: got %b expected 1", proto_err2); else passed++;
    push_req(WE_READ, 16'h0020, 16'h0000); exp_rd2++;
    drive2(WE_READ, 16'h0020, 16'h0000, dout, lat, to);
    e = sb_q.pop_front();
    checks++; if (to || !e.chk || dout !== e.dout) $display("[TB] FAIL proto_clean_read: got %h expected %h", dout, e.dout); else passed++;
    checks++; if (proto_err2 !== 1'b1) $display("[TB] FAIL proto_sticky: got %b expected 1", proto_err2); else passed++;
    checks++; if (rd_count2 !== 16'(exp_rd2)) $display("[TB] FAIL proto_rd_count: got %0d expected %0d", rd_count2, exp_rd2); else passed++;
  endtask

  // Three-instruction program on the pass-through instance: STW then two LDWs
  // into R1 and R2, one per cycle with no stall.
  task automatic test_latency0();
    exp_t e;
    logic [15:0] r1, r2;
    sb_q.push_back('{dout: 16'h0005, chk: 1'b1});
    sb_q.push_back('{dout: 16'h0005, chk: 1'b1});
    @(posedge clk); #1;
    dc0.dcache_en = 1'b1; dc0.dcache_we = WE_WORD; dc0.dcache_addr = 16'h0000; dc0.dcache_din = 16'h0005;
    #1;
    checks++; if (dc0.dcache_r !== 1'b1) $display("[TB] FAIL l0_stw_r: got %b expected 1", dc0.dcache_r); else passed++;
    @(posedge clk); #1;
    dc0.dcache_we = WE_READ; dc0.dcache_din = 16'h0000;
    #1;
    r1 = dc0.dcache_dout;
    checks++; if (dc0.dcache_r !== 1'b1) $display("[TB] FAIL l0_ldw1_r: got %b expected 1", dc0.dcache_r); else passed++;
    e = sb_q.pop_front();
    checks++; if (r1 !== e.dout) $display("[TB] FAIL l0_r1: got %h expected %h", r1, e.dout); else passed++;
    @(posedge clk); #1;
    #1;
    r2 = dc0.dcache_dout;
    checks++; if (dc0.dcache_r !== 1'b1) $display("[TB] FAIL l0_ldw2_r: got %b expected 1", dc0.dcache_r); else passed++;
    e = sb_q.pop_front();
    checks++; if (r2 !== e.dout) $display("[TB] FAIL l0_r2: got %h expected %h", r2, e.dout); else passed++;
    @(posedge clk); #1;
    dc0.dcache_en = 1'b0;
    #1;
    checks++; if (dc0.dcache_r !== 1'b0 || dc0.dcache_dout !== 16'h0000)
      $display("[TB] FAIL l0_idle: got r=%b dout=%h expected 0/0000", dc0.dcache_r, dc0.dcache_dout); else passed++;
    checks++; if (rd_count0 !== 16'd2 || wr_count0 !== 16'd1)
      $display("[TB] FAIL l0_counts: got rd=%0d wr=%0d expected 2/1", rd_count0, wr_count0); else passed++;
    checks++; if (proto_err0 !== 1'b0) $display("[TB] FAIL l0_proto: got %b expected 0", proto_err0); else passed++;
  endtask

  task automatic test_reset_mid_wait();
    logic [15:0] dout; int lat; bit to; exp_t e;
    @(posedge clk); #1;
    dc2.dcache_en = 1'b1; dc2.dcache_we = WE_WORD; dc2.dcache_addr = 16'h0000; dc2.dcache_din = 16'h7777;
    @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    checks++; if (dc2.dcache_r !== 1'b0 || dc2.dcache_dout !== 16'h0000)
      $display("[TB] FAIL rst_wait_outputs: got r=%b dout=%h expected 0/0000", dc2.dcache_r, dc2.dcache_dout); else passed++;
    checks++; if (proto_err2 !== 1'b0 || rd_count2 !== 16'd0 || wr_count2 !== 16'd0)
      $display("[TB] FAIL rst_wait_status: got proto=%b rd=%0d wr=%0d expected 0/0/0", proto_err2, rd_count2, wr_count2); else passed++;
    dc2.dcache_en = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    exp_rd2 = 0; exp_wr2 = 0;
    push_req(WE_READ, 16'h0000, 16'h0000); exp_rd2++;
    drive2(WE_READ, 16'h0000, 16'h0000, dout, lat, to);
    e = sb_q.pop_front();
    checks++; if (to || !e.chk || dout !== e.dout) $display("[TB] FAIL rst_no_write: got %h expected %h", dout, e.dout); else passed++;
    checks++; if (rd_count2 !== 16'(exp_rd2) || wr_count2 !== 16'(exp_wr2))
      $display("[TB] FAIL rst_counts_after: got rd=%0d wr=%0d expected %0d/%0d", rd_count2, wr_count2, exp_rd2, exp_wr2); else passed++;
    checks++; if (sb_q.size() != 0) $display("[TB] FAIL scoreboard_drain: got %0d entries expected 0", sb_q.size()); else passed++;
  endtask

  initial begin
    $display("[TB] starting lc3bp_dcache_responder bench");
    test_reset();
    test_store_load();
    test_byte_writes();
    test_abort();
    test_back_to_back();
    test_proto_err();
    test_latency0();
    test_reset_mid_wait();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule

// File: doc/lc3bp_dcache_responder.md
# lc3bp_dcache_responder

Responder end of the LC3B pipeline's D-cache request interface: it accepts the core MEM-stage request (`dcache_en`/`dcache_we`/`dcache_addr`/`dcache_din`), inserts a programmable number of wait states, and returns `dcache_r`/`dcache_dout`. It also commits byte-enabled writes to an internal word-organised data memory. It sits beside `LC3BP_TOP_FULL` in the full-system build, replacing the zero-wait behavioural DMEM so the core's MEM-stage stall path is exercised.

## Interface
- `LATENCY`, default 2: wait cycles before `dcache_r`; legal range 0..15.
- `DEPTH_WORDS`, default 32768: number of 16-bit words; word index is `dcache_addr[15:1]` modulo DEPTH_WORDS.
- `clk` input 1: sole clock; all state updates on posedge.
- `rst_n` input 1: asynchronous, active-low reset.
- `dcache_en` input 1: request valid; the core holds it and the other request fields stable until it samples `dcache_r`=1.
- `dcache_we` input 2: byte write enables; bit0 = [7:0], bit1 = [15:8]; 00 = read.
- `dcache_addr` input 16: byte address; bit0 ignored for word selection.
- `dcache_din` input 16: write data.
- `dcache_r` output 1: request complete; the core advances on the edge where this is 1.
- `dcache_dout` output 16: full read word, valid while `dcache_r`=1.
- `proto_err` output 1: sticky; request fields changed while a request was in flight.
- `rd_count` output 16: completed reads, wraps at 0xFFFF→0.
- `wr_count` output 16: completed writes (`we`≠00), wraps.

## Operation
- States: IDLE, WAIT, DONE. These apply only when LATENCY≥1.
- IDLE with `dcache_en`=1:
  - Latch addr/we/din and set cnt=LATENCY−1.
  - If cnt=0, go to DONE and load `dcache_dout`←mem[idx]; otherwise go to WAIT.
- WAIT:
  - `dcache_en`=0 means abort: go to IDLE, no write, no count.
  - Otherwise decrement cnt. At cnt=1, load `dcache_dout` and go to DONE.
- DONE (`dcache_r`=1):
  - At the edge, if `dcache_en`=1: perform the byte-enabled write of the latched din, increment rd_count or wr_count, go to IDLE.
  - If `dcache_en`=0: abort, no write, no count, go to IDLE.
- DONE always returns to IDLE. A back-to-back request is re-accepted in the following IDLE cycle.
- Read data is the pre-write word. A write-request's `dcache_dout` shows the old contents.
- Protocol check: in WAIT or DONE with `dcache_en`=1, any difference between the live addr/we/din and the latched values sets `proto_err`. The latched values remain authoritative.
- `proto_err` clears only on reset.
- LATENCY=0 is a pass-through:
  - `dcache_r`=`dcache_en` and `dcache_dout`=mem[idx] combinationally (0 when en=0).
  - The write commits at every edge with en=1 and we≠00; counters update at the same edge.
  - `proto_err` is never set.
- Memory contents are not reset and are uninitialised at time 0. Reset mid-request discards the request with no write.

## Timing
- Reset values: state IDLE, `dcache_r`=0, `dcache_dout`=0, `proto_err`=0, both counts 0.
- Request first seen in cycle c (IDLE): `dcache_r`=1 in cycle c+LATENCY only; the write lands at the end of cycle c+LATENCY.
- `dcache_dout` is registered for LATENCY≥1 and held through DONE.
- Throughput is one access per LATENCY+1 cycles for LATENCY≥1, and one per cycle for LATENCY=0.
- `dcache_r` is a registered function of state (high exactly in DONE), not of `dcache_en`, for LATENCY≥1.

## Structure
- Package `lc3bp_mem_pkg`:
  - state enum `dresp_state_t` {IDLE, WAIT, DONE}.
  - constants `WE_READ`=2'b00, `WE_LO`=2'b01, `WE_HI`=2'b10, `WE_WORD`=2'b11.
- Sub-module `lc3bp_dmem_array`: DEPTH_WORDS×16 RAM with a 2-bit byte-enable synchronous write, a synchronous read port, and an asynchronous read port (used only when LATENCY=0).
- The FSM, latch registers, counters and protocol check live in the top module.

## Test plan
- LATENCY=2, STW 0x0005 to addr 0x0000 (we=11): `dcache_r` high in the 3rd cycle after en rises; mem[0]=0x0005; wr_count=1.
- Then LDW from 0x0000: `dcache_dout`=0x0005 while r=1; rd_count=1.
- Byte writes: we=01 with din=0x12AB to 0x0010, then we=10 with din=0xCD34 to 0x0011; a word read of 0x0010 returns 0xCDAB.
- Abort: drop en during WAIT of a write of 0xBEEF to 0x0020: no write (mem unchanged), counts unchanged, FSM back to IDLE.
- Change addr during WAIT: `proto_err`=1 and stays 1; the access uses the originally latched address.
- LATENCY=0: the same STW/LDW sequence completes with r=1 in the request cycle, giving a 3-instruction program with R1=R2=mem[0]=0x0005 and no core stalls. Reset asserted mid-WAIT returns all outputs to their reset values.
